// File: rtl/arb_cpu_core.sv
// Multi-cycle fetch/execute/memory CPU core with an internal register file and ALU.
// One shared instruction/data memory is reached through a req/ack handshake.
module arb_cpu_core #(
    parameter int              XLEN     = 19,
    parameter int              REG_AW   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result,
    output logic            retire,
    output logic            halted
);

    localparam int              NREGS = 2 ** REG_AW;
    localparam int              IMM_W = XLEN - 4 - REG_AW;
    localparam logic [XLEN-1:0] ONE   = XLEN'(1);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV  = 4'h3,
        OP_INC  = 4'h4, OP_DEC = 4'h5, OP_AND = 4'h6, OP_OR   = 4'h7,
        OP_XOR  = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_LD   = 4'hB,
        OP_ST   = 4'hC, OP_BEQZ = 4'hD, OP_HALT = 4'hE, OP_JMP = 4'hF
    } op_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ir_q, ir_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];

    op_e               op;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [XLEN-1:0]   imm, rd_val, rs1_val, rs2_val, pc_inc, alu_y;
    logic              mem_req_c;

    assign op      = op_e'(ir_q[XLEN-1 -: 4]);
    assign rd      = ir_q[XLEN-5 -: REG_AW];
    assign rs1     = ir_q[XLEN-5-REG_AW -: REG_AW];
    assign rs2     = ir_q[XLEN-5-2*REG_AW -: REG_AW];
    assign imm     = XLEN'(ir_q[IMM_W-1:0]);
    assign rd_val  = regs_q[rd];
    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];
    assign pc_inc  = pc_q + ONE;

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        alu_y = '0;
        case (op)
            OP_ADD:  alu_y = rs1_val + rs2_val;
            OP_SUB:  alu_y = rs1_val - rs2_val;
            OP_MUL:  alu_y = rs1_val * rs2_val;
            OP_DIV:  alu_y = (rs2_val == '0) ? '1 : rs1_val / rs2_val;
            OP_INC:  alu_y = rs1_val + ONE;
            OP_DEC:  alu_y = rs1_val - ONE;
            OP_AND:  alu_y = rs1_val & rs2_val;
            OP_OR:   alu_y = rs1_val | rs2_val;
            OP_XOR:  alu_y = rs1_val ^ rs2_val;
            OP_NOT:  alu_y = ~rs1_val;
            OP_LDI:  alu_y = imm;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        result_d  = result_q;
        regs_d    = regs_q;
        mem_req_c = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                mem_addr  = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_LD, OP_ST: state_d = S_MEM;
                    OP_BEQZ: begin
                        pc_d    = (rd_val == '0) ? imm : pc_inc;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = imm;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        regs_d[rd] = alu_y;
                        result_d   = alu_y;
                        pc_d       = pc_inc;
                        retire     = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                // Address, direction and data come from registers that cannot change while waiting.
                mem_req_c = 1'b1;
                mem_addr  = rs1_val;
                mem_we    = (op == OP_ST);
                mem_wdata = rd_val;
                if (mem_ack) begin
                    if (op == OP_LD) begin
                        regs_d[rd] = mem_rdata;
                        result_d   = mem_rdata;
                    end
                    pc_d    = pc_inc;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so the request is masked to drop it the moment reset rises.
    assign mem_req = mem_req_c & ~reset;
    assign pc      = pc_q;
    assign result  = result_q;
    assign halted  = (state_q == S_HALT);

    // NOTE: sequential state uses non-blocking assignments only; the register file is reset
    // because programs rely on every register reading zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            result_q <= '0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            regs_q   <= regs_d;
        end
    end

endmodule
